// File: rtl/mips_regfile.sv
// 32x32 MIPS-lite register file: two bypassed combinational read ports,
// one write port, hardwired-zero $0, debug read port, saturating write count.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   rs_addr / rd_data1   read port 1 (ALU operand a)
//   rt_addr / rd_data2   read port 2 (ALU operand b path)
//   wr_en/wr_addr/wr_data write-back port
//   dbg_addr / dbg_data  committed-state read, no bypass
//   wr_count             committed writes since reset, saturating
module mips_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       wr_count_q;
  logic [15:0]       wr_count_d;

  // A write is live only out of reset and never to $0.
  logic wr_live;
  logic wr_commit;

  assign wr_live   = wr_en & rst_n;
  assign wr_commit = wr_live & (wr_addr != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_d[i] = '0;
      end
      wr_count_d = '0;
    end else if (wr_commit) begin
      regs_d[wr_addr] = wr_data;
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    wr_count_q <= wr_count_d;
  end

  // Same-cycle bypass so the ALU sees a value being written this cycle.
  always_comb begin
    rd_data1 = '0;
    if (rs_addr != '0) begin
      if (wr_live && (wr_addr == rs_addr)) begin
        rd_data1 = wr_data;
      end else begin
        rd_data1 = regs_q[rs_addr];
      end
    end
  end

  always_comb begin
    rd_data2 = '0;
    if (rt_addr != '0) begin
      if (wr_live && (wr_addr == rt_addr)) begin
        rd_data2 = wr_data;
      end else begin
        rd_data2 = regs_q[rt_addr];
      end
    end
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: array model compared every cycle
// plus directed literal checks.
module tb_mips_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] rd_data1, rd_data2, wr_data, dbg_data;
  logic        wr_en;
  logic [15:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [32];
  int          m_cnt;
  bit          m_valid = 1'b0;

  always #5 clk = ~clk;

  mips_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain array + counter updated at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_cnt   <= 0;
      m_valid <= 1'b1;
    end else if (wr_en === 1'b1 && wr_addr != 5'd0) begin
      m_regs[wr_addr] <= wr_data;
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  end

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (rst_n && wr_en === 1'b1 && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_data1", rd_data1, m_read(rs_addr));
      check("rd_data2", rd_data2, m_read(rt_addr));
      check("dbg_data", dbg_data,
            (dbg_addr == 5'd0) ? 32'h0 : m_regs[dbg_addr]);
      check("wr_count", {16'h0, wr_count}, m_cnt[31:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    cyc(); cyc();
    rst_n = 1'b1;

    // Reset clear
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 1'b0; dbg_addr = 5'd5;
    #2 check("preload5", dbg_data, 32'hDEADBEEF);
    rst_n = 1'b0; rs_addr = 5'd5;
    cyc();
    rst_n = 1'b1;
    #2;
    check("rst_dbg5", dbg_data, 32'h0);
    check("rst_cnt", {16'h0, wr_count}, 32'h0);
    check("rst_rd1", rd_data1, 32'h0);

    // Basic write/read
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h7;
    cyc();
    wr_en = 1'b0; rs_addr = 5'd3; rt_addr = 5'd3;
    #2;
    check("wr3_rd1", rd_data1, 32'h7);
    check("wr3_rd2", rd_data2, 32'h7);
    check("wr3_cnt", {16'h0, wr_count}, 32'd1);

    // $0 protection
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0;
    #2 check("z0_same", rd_data1, 32'h0);
    cyc();
    wr_en = 1'b0;
    #2;
    check("z0_next", rd_data1, 32'h0);
    check("z0_cnt", {16'h0, wr_count}, 32'd1);

    // Bypass
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h1;
    cyc();
    wr_data = 32'h1234; rs_addr = 5'd8; rt_addr = 5'd8; dbg_addr = 5'd8;
    #2;
    check("byp_rd1", rd_data1, 32'h1234);
    check("byp_rd2", rd_data2, 32'h1234);
    check("byp_dbg_pre", dbg_data, 32'h1);
    cyc();
    wr_en = 1'b0;
    #2;
    check("byp_dbg_post", dbg_data, 32'h1234);
    check("byp_cnt", {16'h0, wr_count}, 32'd3);

    // Reset wins over write
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd5;
    rs_addr = 5'd9;
    #2 check("rstw_rd1", rd_data1, 32'h0);
    cyc();
    rst_n = 1'b1; wr_en = 1'b0; dbg_addr = 5'd9;
    #2;
    check("rstw_dbg9", dbg_data, 32'h0);
    check("rstw_cnt", {16'h0, wr_count}, 32'h0);

    // Full sweep
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = i * 32'h01010101;
      cyc();
    end
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i + 1); dbg_addr = 5'(i);
      #2;
      check("sweep_rd1", rd_data1, i * 32'h01010101);
      check("sweep_rd2", rd_data2, (32 - i) * 32'h01010101);
      cyc();
    end
    check("sweep_cnt", {16'h0, wr_count}, 32'd31);

    // Saturation
    wr_en = 1'b1;
    for (int k = 0; k < 65600; k++) begin
      wr_addr = 5'(1 + (k % 31)); wr_data = k;
      rs_addr = 5'(1 + ((k + 3) % 31)); rt_addr = wr_addr;
      cyc();
    end
    wr_en = 1'b0;
    #2 check("sat_cnt", {16'h0, wr_count}, 32'h0000_FFFF);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
